// File: rtl/baud_gen_prog_if.sv
// Control and tick bundle between baud_gen_prog and the UART TX/RX paths.
// Strobes (inc_wr, resync) are single-cycle and always accepted; there is no backpressure.
interface baud_gen_prog_if #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned OVS_FACTOR = 16
);
    localparam int unsigned PW = $clog2(OVS_FACTOR);

    logic                 enable;
    logic [ACC_WIDTH-1:0] inc_in;
    logic                 inc_wr;
    logic                 resync;
    logic                 tick_ovs;
    logic                 baud_tick;
    logic                 mid_tick;
    logic [PW-1:0]        ovs_phase;
    logic                 inc_pending;

    modport master (
        output enable, inc_in, inc_wr, resync,
        input  tick_ovs, baud_tick, mid_tick, ovs_phase, inc_pending
    );

    modport slave (
        input  enable, inc_in, inc_wr, resync,
        output tick_ovs, baud_tick, mid_tick, ovs_phase, inc_pending
    );
endinterface

// File: rtl/baud_gen_prog.sv
// Phase-accumulator baud/oversample tick generator with glitch-free runtime rate change
// and bit-phase resynchronisation for the UART RX start-bit detector.
module baud_gen_prog #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned DEFAULT_BAUD = 115200,
    parameter int unsigned OVS_FACTOR   = 16,
    parameter int unsigned ACC_WIDTH    = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    baud_gen_prog_if.slave  bus
);
    localparam int unsigned CW = $clog2(OVS_FACTOR);

    // Rounded DEFAULT_BAUD*OVS*2^W/CLK_FREQ, evaluated wide so no intermediate overflows.
    localparam logic [127:0] DEF_NUM      = (128'(DEFAULT_BAUD) * 128'(OVS_FACTOR)) << ACC_WIDTH;
    localparam logic [127:0] DEF_INC_WIDE = (DEF_NUM + 128'(CLK_FREQ / 2)) / 128'(CLK_FREQ);
    localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = DEF_INC_WIDE[ACC_WIDTH-1:0];

    localparam logic [CW-1:0] CNT_LAST    = CW'(OVS_FACTOR - 1);
    localparam logic [CW-1:0] CNT_MID_PRE = CW'(OVS_FACTOR / 2 - 1);

    generate
        if (OVS_FACTOR < 4 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
            $error("baud_gen_prog: OVS_FACTOR must be a power of 2 and >= 4");
        end
        if (DEF_INC_WIDE == 128'd0 || DEF_INC_WIDE >= (128'd1 << ACC_WIDTH)) begin : g_bad_inc
            $error("baud_gen_prog: DEFAULT_INC out of range for ACC_WIDTH");
        end
    endgenerate

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] inc_active_q, inc_active_d;
    logic [ACC_WIDTH-1:0] inc_next_q, inc_next_d;
    logic                 pending_q, pending_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tick_ovs_q, tick_ovs_d;
    logic                 baud_tick_q, baud_tick_d;
    logic                 mid_tick_q, mid_tick_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    always_comb begin
        sum          = {1'b0, acc_q} + {1'b0, inc_active_q};
        carry        = sum[ACC_WIDTH];
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        inc_active_d = inc_active_q;
        inc_next_d   = inc_next_q;
        pending_d    = pending_q;
        tick_ovs_d   = 1'b0;
        baud_tick_d  = 1'b0;
        mid_tick_d   = 1'b0;

        if (bus.resync) begin
            // Restart bit phase; a simultaneous write bypasses the pending stage.
            acc_d     = '0;
            cnt_d     = '0;
            pending_d = 1'b0;
            if (bus.inc_wr) begin
                inc_active_d = bus.inc_in;
                inc_next_d   = bus.inc_in;
            end else if (pending_q) begin
                inc_active_d = inc_next_q;
            end
        end else begin
            if (bus.enable) begin
                acc_d = sum[ACC_WIDTH-1:0];
                if (carry) begin
                    cnt_d       = cnt_q + CW'(1);
                    tick_ovs_d  = 1'b1;
                    baud_tick_d = (cnt_q == CNT_LAST);
                    mid_tick_d  = (cnt_q == CNT_MID_PRE);
                end
            end
            // Swap rates only on a carry so one oversample period never mixes two rates.
            if (pending_q && (!bus.enable || carry)) begin
                inc_active_d = inc_next_q;
                pending_d    = 1'b0;
            end
            if (bus.inc_wr) begin
                inc_next_d = bus.inc_in;
                pending_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            inc_active_q <= DEFAULT_INC;
            inc_next_q   <= DEFAULT_INC;
            pending_q    <= 1'b0;
            tick_ovs_q   <= 1'b0;
            baud_tick_q  <= 1'b0;
            mid_tick_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            inc_active_q <= inc_active_d;
            inc_next_q   <= inc_next_d;
            pending_q    <= pending_d;
            tick_ovs_q   <= tick_ovs_d;
            baud_tick_q  <= baud_tick_d;
            mid_tick_q   <= mid_tick_d;
        end
    end

    assign bus.tick_ovs    = tick_ovs_q;
    assign bus.baud_tick   = baud_tick_q;
    assign bus.mid_tick    = mid_tick_q;
    assign bus.ovs_phase   = cnt_q;
    assign bus.inc_pending = pending_q;
endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog: fixed-rate, resync, rate change, enable/zero-inc,
// reset-during-pending and default-rate spacing scenarios.
module tb_baud_gen_prog;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    baud_gen_prog_if #(.ACC_WIDTH(32), .OVS_FACTOR(16)) bus ();

    baud_gen_prog #(
        .CLK_FREQ    (100000000),
        .DEFAULT_BAUD(115200),
        .OVS_FACTOR  (16),
        .ACC_WIDTH   (32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.enable  = 1'b1;
        bus.inc_in  = '0;
        bus.inc_wr  = 1'b0;
        bus.resync  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({bus.tick_ovs, bus.baud_tick, bus.mid_tick, bus.ovs_phase, bus.inc_pending} !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_hold got tick=%b baud=%b mid=%b phase=%0d pend=%b want all 0",
                         bus.tick_ovs, bus.baud_tick, bus.mid_tick, bus.ovs_phase, bus.inc_pending);
            end
        end
        reset_n = 1'b1;
        step();
        tests_run++;
        if ({bus.tick_ovs, bus.baud_tick, bus.mid_tick, bus.ovs_phase, bus.inc_pending} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_after got tick=%b baud=%b mid=%b phase=%0d pend=%b want all 0",
                     bus.tick_ovs, bus.baud_tick, bus.mid_tick, bus.ovs_phase, bus.inc_pending);
        end
    endtask

    task automatic test_fast_ticks();
        logic       exp_tick, exp_mid, exp_baud;
        logic [3:0] exp_phase;
        bus.inc_in = 32'h8000_0000;
        bus.inc_wr = 1'b1;
        step();
        bus.inc_wr = 1'b0;
        tests_run++;
        if (bus.inc_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL fast_pending got %b want 1", bus.inc_pending);
        end
        bus.resync = 1'b1;
        step();
        bus.resync = 1'b0;
        tests_run++;
        if (bus.tick_ovs !== 1'b0 || bus.ovs_phase !== 4'd0 || bus.inc_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL fast_resync got tick=%b phase=%0d pend=%b want 0 0 0",
                     bus.tick_ovs, bus.ovs_phase, bus.inc_pending);
        end
        for (int t = 1; t <= 70; t++) begin
            step();
            exp_tick  = (t % 2 == 0);
            exp_phase = 4'((t / 2) % 16);
            exp_mid   = exp_tick && (exp_phase == 4'd8);
            exp_baud  = exp_tick && (exp_phase == 4'd0);
            tests_run++;
            if (bus.tick_ovs !== exp_tick || bus.mid_tick !== exp_mid ||
                bus.baud_tick !== exp_baud || bus.ovs_phase !== exp_phase) begin
                tests_failed++;
                $display("FAIL fast_ticks t=%0d got tick=%b mid=%b baud=%b phase=%0d want %b %b %b %0d",
                         t, bus.tick_ovs, bus.mid_tick, bus.baud_tick, bus.ovs_phase,
                         exp_tick, exp_mid, exp_baud, exp_phase);
            end
        end
    endtask

    task automatic test_resync_midbit();
        logic       found;
        logic       exp_tick;
        logic [3:0] exp_phase;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.ovs_phase == 4'd11 && bus.tick_ovs == 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++;
            $display("FAIL resync_wait got phase=%0d want 11 within 64 cycles", bus.ovs_phase);
        end
        bus.resync = 1'b1;
        step();
        bus.resync = 1'b0;
        tests_run++;
        if (bus.tick_ovs !== 1'b0 || bus.mid_tick !== 1'b0 || bus.baud_tick !== 1'b0 || bus.ovs_phase !== 4'd0) begin
            tests_failed++;
            $display("FAIL resync_cycle got tick=%b mid=%b baud=%b phase=%0d want 0 0 0 0",
                     bus.tick_ovs, bus.mid_tick, bus.baud_tick, bus.ovs_phase);
        end
        for (int t = 1; t <= 20; t++) begin
            step();
            exp_tick  = (t % 2 == 0);
            exp_phase = 4'((t / 2) % 16);
            tests_run++;
            if (bus.tick_ovs !== exp_tick || bus.ovs_phase !== exp_phase ||
                bus.mid_tick !== (t == 16) || bus.baud_tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL resync_after t=%0d got tick=%b mid=%b baud=%b phase=%0d want %b %b 0 %0d",
                         t, bus.tick_ovs, bus.mid_tick, bus.baud_tick, bus.ovs_phase,
                         exp_tick, (t == 16), exp_phase);
            end
        end
    endtask

    task automatic test_rate_change();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.tick_ovs == 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++;
            $display("FAIL rate_wait got no tick want tick within 8 cycles");
        end
        bus.inc_in = 32'h4000_0000;
        bus.inc_wr = 1'b1;
        step();
        bus.inc_wr = 1'b0;
        tests_run++;
        if (bus.inc_pending !== 1'b1 || bus.tick_ovs !== 1'b0) begin
            tests_failed++;
            $display("FAIL rate_pending got pend=%b tick=%b want 1 0", bus.inc_pending, bus.tick_ovs);
        end
        step();
        tests_run++;
        if (bus.tick_ovs !== 1'b1 || bus.inc_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL rate_apply got tick=%b pend=%b want 1 0", bus.tick_ovs, bus.inc_pending);
        end
        for (int t = 1; t <= 12; t++) begin
            step();
            tests_run++;
            if (bus.tick_ovs !== (t % 4 == 0) || bus.inc_pending !== 1'b0) begin
                tests_failed++;
                $display("FAIL rate_spacing t=%0d got tick=%b pend=%b want %b 0",
                         t, bus.tick_ovs, bus.inc_pending, (t % 4 == 0));
            end
        end
    endtask

    task automatic test_enable_zero_inc();
        logic       exp_tick;
        logic [3:0] exp_phase;
        bus.resync = 1'b1;
        step();
        bus.resync = 1'b0;
        for (int t = 1; t <= 9; t++) step();
        tests_run++;
        if (bus.ovs_phase !== 4'd2) begin
            tests_failed++;
            $display("FAIL en_setup got phase=%0d want 2", bus.ovs_phase);
        end
        bus.enable = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            step();
            tests_run++;
            if ({bus.tick_ovs, bus.mid_tick, bus.baud_tick} !== 3'b000 || bus.ovs_phase !== 4'd2) begin
                tests_failed++;
                $display("FAIL en_low t=%0d got tick=%b mid=%b baud=%b phase=%0d want 0 0 0 2",
                         t, bus.tick_ovs, bus.mid_tick, bus.baud_tick, bus.ovs_phase);
            end
        end
        bus.inc_in = '0;
        bus.inc_wr = 1'b1;
        step();
        bus.inc_wr = 1'b0;
        tests_run++;
        if (bus.inc_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_wr got pend=%b want 1", bus.inc_pending);
        end
        step();
        tests_run++;
        if (bus.inc_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_apply got pend=%b want 0", bus.inc_pending);
        end
        bus.enable = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            step();
            tests_run++;
            if ({bus.tick_ovs, bus.mid_tick, bus.baud_tick} !== 3'b000 || bus.ovs_phase !== 4'd2) begin
                tests_failed++;
                $display("FAIL zero_inc t=%0d got tick=%b mid=%b baud=%b phase=%0d want 0 0 0 2",
                         t, bus.tick_ovs, bus.mid_tick, bus.baud_tick, bus.ovs_phase);
            end
        end
        bus.enable = 1'b0;
        bus.inc_in = 32'h4000_0000;
        bus.inc_wr = 1'b1;
        step();
        bus.inc_wr = 1'b0;
        step();
        bus.enable = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            exp_tick  = (t == 3 || t == 7);
            exp_phase = (t < 3) ? 4'd2 : (t < 7) ? 4'd3 : 4'd4;
            tests_run++;
            if (bus.tick_ovs !== exp_tick || bus.ovs_phase !== exp_phase) begin
                tests_failed++;
                $display("FAIL en_resume t=%0d got tick=%b phase=%0d want %b %0d",
                         t, bus.tick_ovs, bus.ovs_phase, exp_tick, exp_phase);
            end
        end
    endtask

    task automatic test_reset_pending();
        bus.inc_in = 32'h8000_0000;
        bus.inc_wr = 1'b1;
        step();
        bus.inc_wr = 1'b0;
        tests_run++;
        if (bus.inc_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstpend_set got pend=%b want 1", bus.inc_pending);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        tests_run++;
        if ({bus.tick_ovs, bus.baud_tick, bus.mid_tick, bus.ovs_phase, bus.inc_pending} !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstpend_clear got tick=%b baud=%b mid=%b phase=%0d pend=%b want all 0",
                     bus.tick_ovs, bus.baud_tick, bus.mid_tick, bus.ovs_phase, bus.inc_pending);
        end
        // DEFAULT_INC = 79164837: first carry needs ceil(2^32/79164837) = 55 additions.
        for (int t = 1; t <= 55; t++) begin
            step();
            tests_run++;
            if (bus.tick_ovs !== (t == 55) || bus.inc_pending !== 1'b0 ||
                bus.ovs_phase !== ((t == 55) ? 4'd1 : 4'd0)) begin
                tests_failed++;
                $display("FAIL rstpend_rate t=%0d got tick=%b pend=%b phase=%0d want %b 0 %0d",
                         t, bus.tick_ovs, bus.inc_pending, bus.ovs_phase, (t == 55), (t == 55) ? 1 : 0);
            end
        end
    endtask

    task automatic test_default_rate();
        int last_tick, first_baud, last_baud, nbaud, spacing;
        last_tick  = 0;
        first_baud = 0;
        last_baud  = 0;
        nbaud      = 0;
        for (int cyc = 1; cyc <= 25000 && nbaud <= 20; cyc++) begin
            step();
            if (bus.tick_ovs) begin
                spacing = cyc - last_tick;
                last_tick = cyc;
                tests_run++;
                if (spacing != 54 && spacing != 55) begin
                    tests_failed++;
                    $display("FAIL def_ovs_spacing got %0d want 54 or 55", spacing);
                end
            end
            if (bus.baud_tick) begin
                if (nbaud == 0) begin
                    first_baud = cyc;
                end else begin
                    spacing = cyc - last_baud;
                    tests_run++;
                    if (spacing != 868 && spacing != 869) begin
                        tests_failed++;
                        $display("FAIL def_baud_spacing got %0d want 868 or 869", spacing);
                    end
                end
                last_baud = cyc;
                if (nbaud == 20) begin
                    // 20 bits * 16 * 2^32 / 79164837 = 17361.11 cycles.
                    spacing = cyc - first_baud;
                    tests_run++;
                    if (spacing < 17360 || spacing > 17362) begin
                        tests_failed++;
                        $display("FAIL def_total_20bits got %0d want 17360..17362", spacing);
                    end
                end
                nbaud++;
            end
        end
        tests_run++;
        if (nbaud != 21) begin
            tests_failed++;
            $display("FAIL def_baud_count got %0d want 21", nbaud);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fast_ticks();
        test_resync_midbit();
        test_rate_change();
        test_enable_zero_inc();
        test_reset_pending();
        test_default_rate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/baud_gen_prog.md
# baud_gen_prog

Runtime-programmable, phase-resynchronisable baud/oversample tick generator for the UART TX and RX paths. A W-bit phase accumulator adds a programmable increment every clock. Each carry-out produces one oversample tick. A modulo-OVS_FACTOR counter derives the bit-rate tick and a mid-bit sample tick from those. The RX start-bit detector uses `resync` to realign bit phase; software changes the baud rate through `inc_wr` without glitching the tick stream.

## Interface
- CLK_FREQ, 100000000: system clock in Hz; used only to compute DEFAULT_INC.
- DEFAULT_BAUD, 115200: baud rate active after reset.
- OVS_FACTOR, 16: oversampling factor. Must be a power of 2 and ≥ 4; elaboration fails otherwise.
- ACC_WIDTH, 32: accumulator and increment width W.
- DEFAULT_INC, round(DEFAULT_BAUD·OVS_FACTOR·2^W / CLK_FREQ): derived localparam. Must be nonzero and < 2^W.
- clk  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  high: accumulator runs; low: accumulator and counter hold.
- inc_in  in  W  new increment value.
- inc_wr  in  1  one-cycle strobe that captures inc_in.
- resync  in  1  one-cycle strobe that restarts bit phase.
- tick_ovs  out  1  one-cycle oversample tick.
- baud_tick  out  1  one-cycle tick at end of each bit period.
- mid_tick  out  1  one-cycle tick at bit centre.
- ovs_phase  out  log2(OVS_FACTOR)  current oversample counter value.
- inc_pending  out  1  a captured increment is waiting to be applied.

## Operation
- State:
  - acc[W-1:0]
  - inc_active[W-1:0]
  - inc_next[W-1:0]
  - pending flag
  - ovs counter (log2(OVS_FACTOR) bits)
- Each enabled cycle computes sum = {1'b0,acc} + {1'b0,inc_active} at W+1 bits. Then acc ← sum[W-1:0] and carry = sum[W].
- carry=1: ovs counter increments, wrapping OVS_FACTOR-1 → 0.
- Counter transition OVS_FACTOR-1 → 0: baud_tick.
- Counter transition OVS_FACTOR/2-1 → OVS_FACTOR/2: mid_tick.
- Increment update:
  - inc_wr captures inc_in into inc_next and sets pending.
  - A later inc_wr before application overwrites inc_next; the last value wins.
  - Pending is applied (inc_active ← inc_next, pending cleared) in the first cycle that has a carry, so tick spacing never mixes two rates within one oversample period.
  - Pending is applied immediately when enable=0 or resync=1.
- resync:
  - Next cycle: acc ← 0, ovs counter ← 0, pending applied.
  - No ticks are generated for that cycle even if a carry would have occurred.
  - After resync, the first mid_tick follows OVS_FACTOR/2 carries and the first baud_tick follows OVS_FACTOR carries.
- inc_in = 0 is legal: no ticks, counter holds.
- enable=0: acc and counter hold; all tick outputs are 0 from the next cycle.
- Priority when events coincide:
  - reset_n low > resync > enable low > normal accumulation.
  - inc_wr in the same cycle as resync: the new inc_in takes effect immediately and pending ends 0.
  - inc_wr in the same cycle as a carry: the carry applies the previously pending value (if any); the new value becomes pending.

## Timing
- Reset values, held while reset_n is low and one cycle after:
  - acc = 0, counter = 0
  - inc_active = DEFAULT_INC, inc_next = DEFAULT_INC, pending = 0
  - tick_ovs, baud_tick, mid_tick = 0
  - ovs_phase = 0, inc_pending = 0
- All outputs are registered. A carry computed in cycle n produces tick_ovs high in cycle n+1 only.
- baud_tick and mid_tick are coincident with the corresponding tick_ovs. ovs_phase shows the post-increment counter value in that same cycle.
- baud_tick and mid_tick are never high together, since OVS_FACTOR ≥ 4.
- The first tick_ovs after reset or resync occurs at cycle ceil(2^W / inc) after it.
- Steady-state tick_ovs spacing is floor(2^W/inc) or ceil(2^W/inc) cycles. Long-term average spacing is exactly 2^W/inc.
- inc_pending rises the cycle after inc_wr and falls the cycle after application.
- Reset asserted mid-bit discards all phase and the pending increment.

## Test plan
- Ticks from inc=2^31, OVS=16, W=32:
  - Stimulus: write inc=2^31, then resync.
  - Required: tick_ovs every 2 cycles, mid_tick 16 cycles after resync, baud_tick every 32 cycles, mid_tick exactly 16 cycles after each baud_tick, ovs_phase cycling 0..15.
- Default rate:
  - Stimulus: 100 MHz, 115200 baud, OVS=16, DEFAULT_INC=79164837.
  - Required: tick_ovs spacings of only 54 and 55 cycles; baud_tick spacings of 868 or 869 cycles; total over 1000 bits within ±1 cycle of 868055.
- Resync mid-bit:
  - Stimulus: resync while ovs_phase=11.
  - Required: no tick that cycle; ovs_phase=0 next cycle; next mid_tick after exactly 8 carries.
- Rate change at tick boundary:
  - Stimulus: inc_wr with inc_in=2^30 midway between carries of inc=2^31.
  - Required: inc_pending=1 until the next carry; spacing switches from 2 to 4 cycles with no intermediate interval.
- Enable low and zero increment:
  - Stimulus: drop enable for 50 cycles, then load inc=0.
  - Required: no ticks in either case; ovs_phase frozen; ticking resumes with the phase retained when enable returns and inc is restored.
- Reset during pending update:
  - Stimulus: reset_n low for 1 cycle while inc_pending=1.
  - Required: all outputs 0, inc_pending=0, and DEFAULT_INC rate restored.
